// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI configuration slave.
// Register map, frame geometry and FSM state encoding.
package spi_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/spi_cfg_if.sv
// SPI pin bundle between the pad ring (master side) and the
// configuration slave.
interface spi_cfg_if;

  logic sclk;
  logic copi;
  logic ncs;

  modport master (
    output sclk,
    output copi,
    output ncs
  );

  modport slave (
    input sclk,
    input copi,
    input ncs
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, plus
// rise/fall pulses taken against one extra delayed flop.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_dly;
  assign o_fall  = ~o_level & r_dly;

endmodule

// File: rtl/spi_cfg_controller.sv
// SPI mode-0 write-only slave that loads the five PWM config
// registers from 16-bit frames: R/W, 7-bit address, 8-bit data.
module spi_cfg_controller
  import spi_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_cfg_if.slave   spi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_wr_stb
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_OVR  = 5'(FRAME_BITS + 1);
  localparam int         ARM_CYC  = SYNC_STAGES + 1;
  localparam int         HW       = $clog2(ARM_CYC + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
  logic w_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (spi.sclk),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (spi.copi),
    .o_level (w_copi_lvl),
    .o_rise  (w_copi_rise),
    .o_fall  (w_copi_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_d     (spi.ncs),
    .o_level (w_ncs_lvl),
    .o_rise  (w_ncs_rise),
    .o_fall  (w_ncs_fall)
  );

  assign w_unused = &{1'b0, w_sclk_lvl, w_sclk_fall,
                      w_copi_rise, w_copi_fall};

  state_t                r_state;
  logic [4:0]            r_cnt;
  logic [FRAME_BITS-1:0] r_sr;
  logic [7:0]            r_out_lo, r_out_hi;
  logic [7:0]            r_pwm_lo, r_pwm_hi;
  logic [7:0]            r_duty;
  logic                  r_stb;
  logic                  r_armed;
  logic [HW-1:0]         r_hi_cnt;

  logic       w_rw;
  logic [6:0] w_addr;
  logic [7:0] w_data;
  logic       w_ok;

  assign w_rw   = r_sr[FRAME_BITS-1];
  assign w_addr = r_sr[FRAME_BITS-2 -: 7];
  assign w_data = r_sr[7:0];
  assign w_ok   = (r_cnt == CNT_FULL) && w_rw &&
                  (w_addr < 7'(NUM_REGS));

  // A falling ncs only opens a frame once ncs has been seen high for
  // real after reset, so a frame cut by reset can never resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sr     <= '0;
      r_out_lo <= '0;
      r_out_hi <= '0;
      r_pwm_lo <= '0;
      r_pwm_hi <= '0;
      r_duty   <= '0;
      r_stb    <= 1'b0;
      r_armed  <= 1'b0;
      r_hi_cnt <= '0;
    end else begin
      r_stb <= 1'b0;

      if (!w_ncs_lvl)
        r_hi_cnt <= '0;
      else if (!r_armed)
        r_hi_cnt <= r_hi_cnt + 1'b1;

      if (w_ncs_rise ||
          (w_ncs_lvl && r_hi_cnt == HW'(ARM_CYC - 1)))
        r_armed <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (w_ncs_fall && r_armed) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_sr    <= '0;
          end
        end
        SHIFT: begin
          if (w_ncs_rise) begin
            r_state <= COMMIT;
          end else if (w_sclk_rise) begin
            r_sr <= {r_sr[FRAME_BITS-2:0], w_copi_lvl};
            if (r_cnt != CNT_OVR)
              r_cnt <= r_cnt + 5'd1;
          end
        end
        COMMIT: begin
          r_state <= IDLE;
          if (w_ok) begin
            r_stb <= 1'b1;
            unique case (1'b1)
              (w_addr == ADDR_EN_OUT_LO): r_out_lo <= w_data;
              (w_addr == ADDR_EN_OUT_HI): r_out_hi <= w_data;
              (w_addr == ADDR_EN_PWM_LO): r_pwm_lo <= w_data;
              (w_addr == ADDR_EN_PWM_HI): r_pwm_hi <= w_data;
              (w_addr == ADDR_DUTY):      r_duty   <= w_data;
              default: ;
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign cfg_wr_stb      = r_stb;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Self-checking bench for spi_cfg_controller: directed frames plus
// random frames against a register-map reference model.
module tb_spi_cfg_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_wr_stb;

  spi_cfg_if spi ();

  spi_cfg_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .cfg_wr_stb      (cfg_wr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_stb = 0;
  int exp_stb = 0;
  logic [7:0] exp_reg [5];

  always @(negedge clk)
    if (rst_n && cfg_wr_stb) n_stb++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b, input int half);
    spi.copi = b;
    cyc(half);
    spi.sclk = 1'b1;
    cyc(half);
    spi.sclk = 1'b0;
  endtask

  // Whole frame, MSB first; returns right after ncs rises.
  task automatic send(input logic [31:0] v, input int n,
                      input int half);
    spi.ncs = 1'b0;
    cyc(half);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i], half);
    cyc(half);
    spi.ncs = 1'b1;
  endtask

  function automatic void model(input logic [31:0] v, input int n);
    logic [6:0] a;
    a = v[14:8];
    if (n == 16 && v[15] && a < 7'd5) begin
      exp_reg[a] = v[7:0];
      exp_stb++;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".r0"}, en_reg_out_7_0,  exp_reg[0]);
    chk({tag, ".r1"}, en_reg_out_15_8, exp_reg[1]);
    chk({tag, ".r2"}, en_reg_pwm_7_0,  exp_reg[2]);
    chk({tag, ".r3"}, en_reg_pwm_15_8, exp_reg[3]);
    chk({tag, ".r4"}, pwm_duty_cycle,  exp_reg[4]);
    chk({tag, ".stb"}, n_stb, exp_stb);
  endtask

  task automatic frame(input string tag, input logic [31:0] v,
                       input int n, input int half);
    send(v, n, half);
    cyc(8);
    model(v, n);
    check_all(tag);
  endtask

  logic [15:0] wr_tbl [5] = '{16'h80FF, 16'h81A5, 16'h82F0,
                              16'h830F, 16'h8480};
  logic [15:0] bad_tbl [3] = '{16'h04AA, 16'h8533, 16'hFF11};
  logic [15:0] bb_tbl [3] = '{16'h8011, 16'h8122, 16'h8433};

  initial begin
    logic [31:0] v;
    logic [15:0] f;
    logic [7:0]  old_duty;
    int          n, r, half;

    rst_n    = 1'b0;
    spi.ncs  = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    model_reset();
    cyc(3);
    chk("init_stb", cfg_wr_stb, 0);
    check_all("init");
    rst_n = 1'b1;
    cyc(10);

    for (int i = 0; i < 5; i++)
      frame($sformatf("wr%0d", i), 32'(wr_tbl[i]), 16, 3);

    // asynchronous reset in the middle of a clock period
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_stb", cfg_wr_stb, 0);
    check_all("arst");
    cyc(2);
    rst_n = 1'b1;
    cyc(10);

    frame("pre", 32'h8155, 16, 4);
    for (int i = 0; i < 3; i++)
      frame($sformatf("bad%0d", i), 32'(bad_tbl[i]), 16, 3);

    frame("dutyA", 32'h8477, 16, 3);
    frame("len15", 32'h8422 >> 1, 15, 3);
    frame("len17", {15'd0, 16'h8422, 1'b1}, 17, 3);
    frame("len16", 32'h8440, 16, 3);

    // reset mid-frame, release with ncs still low
    spi.ncs = 1'b0;
    cyc(3);
    f = 16'h8201;
    for (int i = 15; i >= 8; i--) shift_bit(f[i], 3);
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    for (int i = 15; i >= 0; i--) shift_bit(f[i], 3);
    cyc(3);
    spi.ncs = 1'b1;
    cyc(8);
    check_all("midrst");
    cyc(6);
    frame("postrst", 32'h8201, 16, 3);

    // back-to-back at f_clk/6 with minimum ncs-high gap
    old_duty = exp_reg[4];
    for (int i = 0; i < 3; i++) begin
      send(32'(bb_tbl[i]), 16, 3);
      if (i < 2) cyc(4);
    end
    cyc(3);
    chk("lat_old", pwm_duty_cycle, old_duty);
    cyc(1);
    chk("lat_new", pwm_duty_cycle, 8'h33);
    for (int i = 0; i < 3; i++) model(32'(bb_tbl[i]), 16);
    cyc(6);
    check_all("b2b");

    for (int k = 0; k < 30; k++) begin
      r    = $urandom_range(0, 9);
      half = $urandom_range(3, 5);
      n    = 16;
      v    = {16'd0, 1'b1, 7'($urandom_range(0, 4)), 8'($urandom)};
      if (r == 6) v[15] = 1'b0;
      if (r == 7) v[14:8] = 7'($urandom_range(5, 127));
      if (r == 8) begin n = 15; v = v >> 1; end
      if (r == 9) begin n = 17; v = {v[30:0], 1'($urandom)}; end
      frame($sformatf("rnd%0d", k), v, n, half);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
